eq_seq_ctrl: RTL and testbench
==============================

# eq_seq_ctrl

Sequential equality-compare controller that shares a single 2-bit equality slice (the `eq2` comparator) across a W-bit operand pair. It steps through the operand two bits per cycle, LSB slice first, and accumulates the equality result. It also reports the index of the first mismatching slice. It sits in the comparator library as the small-area alternative to a fully parallel W-bit comparator, driven by a start/done handshake from a host FSM.

## Interface
- `W`, 8, operand width in bits; must be even and ≥ 4; number of slices `S = W/2`.
- `IW`, `$clog2(W/2)`, width of the mismatch index (localparam, derived).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `start` input 1: request a compare; accepted only when `busy` = 0.
- `a` input W: operand A; sampled only on the accepting edge.
- `b` input W: operand B; sampled only on the accepting edge.
- `busy` output 1: compare in progress (CMP state).
- `done` output 1: one-cycle pulse; `eq` and `idx` are valid from this cycle onward.
- `eq` output 1: 1 when `a` = `b` for the last completed compare.
- `idx` output IW: slice index k (bits [2k+1:2k]) of the first mismatch; 0 when `eq` = 1.

## Operation
- The block instantiates exactly one 2-bit equality slice. Its inputs are muxed from the registered operands by the slice counter `cnt` (IW bits).
- States:
  - IDLE: `busy` = 0, `done` = 0.
  - CMP: `busy` = 1, `done` = 0.
  - DONE: `busy` = 0, `done` = 1.
- IDLE / DONE → CMP on an edge with `start` = 1:
  - registers `a` and `b`;
  - `cnt` ← 0, accumulator `acc` ← 1, first-mismatch register `fm` ← 0, mismatch-seen flag ← 0.
- IDLE → IDLE, and DONE → IDLE, when `start` = 0.
- CMP, each edge:
  - `acc` ← `acc` & `slice_eq`.
  - If `slice_eq` = 0 and no earlier mismatch has been seen, `fm` ← `cnt`.
  - `cnt` increments.
- CMP → DONE when `cnt` = S−1 (last slice), or on a mismatch if early exit is compiled in (see Configuration). On this edge:
  - `eq` ← final accumulated value;
  - `idx` ← first mismatch index, or 0 if none.
- `start` while `busy` = 1 is ignored. Changes on `a`/`b` during CMP have no effect.
- `eq` and `idx` hold their values until the next transition into DONE. They are not cleared by a new start.
- Back-to-back: `start` in the DONE cycle is accepted, so the new CMP begins on the next edge.
- `cnt` never wraps. The exit condition at S−1 is checked before the increment.

## Timing
- Reset values (`reset_n` = 0 at an edge): state IDLE, `busy` = 0, `done` = 0, `eq` = 0, `idx` = 0, `cnt` = 0.
- Reset takes priority over all other inputs, including `start`.
- Reset mid-CMP aborts the compare. No `done` is produced and results read as 0.
- Accepting edge is T0:
  - `busy` = 1 for cycles T0+1 … T0+n, where n = number of slices evaluated (1 … S);
  - `done` = 1 for the single cycle after edge T0+n.
- Full-compare latency, start edge to `done` high: S+1 cycles. For W = 8 this is 5.
- Early-exit latency on a mismatch at slice k: k+2 cycles.
- Throughput, with back-to-back starts: one result per n+1 cycles.

## Configuration
- `EQ_SEQ_EARLY_EXIT_EN` defined:
  - CMP → DONE on the first slice with `slice_eq` = 0;
  - variable latency of k+2 cycles.
- `EQ_SEQ_EARLY_EXIT_EN` not defined:
  - always evaluates all S slices, giving constant latency S+1;
  - `idx` still reports the first (lowest) mismatching slice, and later mismatches do not overwrite it.
- Functional results (`eq`, `idx`) are identical in both builds. Only the `busy` length and the `done` timing differ.

## Test plan
- W=8, `a` = `b` = 8'hA5, pulse `start` → `busy` high 4 cycles, `done` pulse in cycle 5 after start, `eq` = 1, `idx` = 0.
- W=8, `a` = 8'h00, `b` = 8'h01:
  - with EN → `busy` 1 cycle, `done` in cycle 2, `eq` = 0, `idx` = 0;
  - without EN → `done` in cycle 5, same `eq`/`idx`.
- W=8, `a` = 8'h81, `b` = 8'h00 (slices 0 and 3 differ) → `eq` = 0, `idx` = 0; without EN `idx` must stay 0, not 3.
- W=8, `a` = 8'h80, `b` = 8'h00 → `eq` = 0, `idx` = 3, `done` in cycle 5 in both builds.
- Start compare of equal operands, then during `busy` change `a` to 8'hFF and pulse `start` again → second `start` ignored, result `eq` = 1, exactly one `done` pulse.
- Drive `reset_n` = 0 for one edge mid-CMP → `busy` = 0, `done` = 0, `eq` = 0, `idx` = 0, no late `done`. A following `start` with `a` = `b` = 8'h3C completes normally with `eq` = 1. Then `start` in the `done` cycle is accepted immediately (`busy` next cycle).

Source files
------------

// File: rtl/eq_seq_ctrl.sv
// eq_seq_ctrl: W-bit equality compare through one shared 2-bit eq2 slice, LSB slice first.
// Define EQ_SEQ_EARLY_EXIT_EN to finish on the first mismatching slice.
module eq2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic       eq
);
    assign eq = (x == y);
endmodule

module eq_seq_ctrl #(
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [W-1:0]           a,
    input  logic [W-1:0]           b,
    output logic                   busy,
    output logic                   done,
    output logic                   eq,
    output logic [$clog2(W/2)-1:0] idx
);
    localparam int S  = W / 2;
    localparam int IW = $clog2(W / 2);

    typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;

    state_t        state, nxt;
    logic [W-1:0]  ra, rb;
    logic [IW-1:0] cnt, fm;
    logic          acc, seen, slice_eq, last, ex, first;

    eq2 u_eq2 (
        .x (ra[{cnt, 1'b0} +: 2]),
        .y (rb[{cnt, 1'b0} +: 2]),
        .eq(slice_eq)
    );

    assign last  = (cnt == IW'(S - 1));
    assign first = ~slice_eq & ~seen;
`ifdef EQ_SEQ_EARLY_EXIT_EN
    assign ex = last | ~slice_eq;
`else
    assign ex = last;
`endif

    always_comb begin
        nxt  = state;
        busy = (state == CMP);
        done = (state == FIN);
        if (state == CMP)
            nxt = ex ? FIN : CMP;
        else
            nxt = start ? CMP : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            cnt   <= '0;
            fm    <= '0;
            acc   <= 1'b0;
            seen  <= 1'b0;
            eq    <= 1'b0;
            idx   <= '0;
        end else begin
            state <= nxt;
            if (state != CMP && start) begin
                ra   <= a;
                rb   <= b;
                cnt  <= '0;
                acc  <= 1'b1;
                fm   <= '0;
                seen <= 1'b0;
            end else if (state == CMP) begin
                acc <= acc & slice_eq;
                if (first) begin
                    fm   <= cnt;
                    seen <= 1'b1;
                end
                // the final slice's mismatch is not yet in fm, so take it straight from cnt
                if (ex) begin
                    eq  <= acc & slice_eq;
                    idx <= first ? cnt : fm;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_eq_seq_ctrl.sv
// tb_eq_seq_ctrl: randomized and directed checks of eq_seq_ctrl against a slice-level reference model.
module tb_eq_seq_ctrl;
    localparam int W  = 8;
    localparam int S  = W / 2;
    localparam int IW = $clog2(S);
`ifdef EQ_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          busy, done, eq;
    logic [IW-1:0] idx;
    int checks = 0, failures = 0;

    eq_seq_ctrl #(.W(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .eq(eq), .idx(idx)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic e, output logic [IW-1:0] k, output int n);
        e = (x == y);
        k = '0;
        for (int i = S - 1; i >= 0; i--)
            if (x[2*i +: 2] != y[2*i +: 2]) k = IW'(i);
        n = (EE && !e) ? int'(k) + 1 : S;
    endfunction

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles (scrambling operands meanwhile), then captures the done-cycle outputs.
    task automatic observe(output int nb, output logic d, output logic e, output logic [IW-1:0] ix);
        nb = 0;
        while (busy === 1'b1 && nb < S + 4) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            nb++;
        end
        d  = done;
        e  = eq;
        ix = idx;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start = 1'b1;
        a = 8'h12;
        b = 8'h12;
        repeat (2) @(negedge clk);
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        if (eq !== 1'b0) begin failures++; $display("FAIL reset_eq: got %b want 0", eq); end
        if (idx !== '0) begin failures++; $display("FAIL reset_idx: got %0d want 0", idx); end
        reset_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [W-1:0]  va[4] = '{8'hA5, 8'h00, 8'h81, 8'h80};
        logic [W-1:0]  vb[4] = '{8'hA5, 8'h01, 8'h00, 8'h00};
        logic [IW-1:0] ki[4] = '{2'd0, 2'd0, 2'd0, 2'd3};
        logic          ke[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic e, d, oe;
        logic [IW-1:0] k, oi;
        int n, nb;
        for (int i = 0; i < 4; i++) begin
            model(va[i], vb[i], e, k, n);
            launch(va[i], vb[i]);
            observe(nb, d, oe, oi);
            checks += 4;
            if (nb != n) begin failures++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, nb, n); end
            if (d !== 1'b1) begin failures++; $display("FAIL dir%0d_done: got %b want 1", i, d); end
            if (oe !== ke[i]) begin failures++; $display("FAIL dir%0d_eq: got %b want %b", i, oe, ke[i]); end
            if (oi !== ki[i]) begin failures++; $display("FAIL dir%0d_idx: got %0d want %0d", i, oi, ki[i]); end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin failures++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] x, y;
        logic e, d, oe;
        logic [IW-1:0] k, oi;
        int n, nb;
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            case ($urandom_range(0, 2))
                0: y = x;
                1: y = x ^ (W'($urandom_range(1, 3)) << (2 * $urandom_range(0, S - 1)));
                default: y = W'($urandom);
            endcase
            model(x, y, e, k, n);
            launch(x, y);
            observe(nb, d, oe, oi);
            checks += 5;
            if (nb != n) begin failures++; $display("FAIL rnd_busy_cycles %h/%h: got %0d want %0d", x, y, nb, n); end
            if (d !== 1'b1) begin failures++; $display("FAIL rnd_done %h/%h: got %b want 1", x, y, d); end
            if (oe !== e) begin failures++; $display("FAIL rnd_eq %h/%h: got %b want %b", x, y, oe, e); end
            if (oi !== k) begin failures++; $display("FAIL rnd_idx %h/%h: got %0d want %0d", x, y, oi, k); end
            @(negedge clk);
            if (done !== 1'b0) begin failures++; $display("FAIL rnd_done_pulse: got %b want 0", done); end
        end
    endtask

    task automatic test_ignore_start;
        int dones = 0;
        logic e = 1'b0;
        launch(8'hA5, 8'hA5);
        a = 8'hFF;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < S + 4; i++) begin
            if (done === 1'b1) begin
                dones++;
                e = eq;
            end
            @(negedge clk);
        end
        checks += 2;
        if (dones != 1) begin failures++; $display("FAIL ign_done_count: got %0d want 1", dones); end
        if (e !== 1'b1) begin failures++; $display("FAIL ign_eq: got %b want 1", e); end
    endtask

    task automatic test_back_to_back;
        int dones = 0, nb, n;
        logic d, oe, e;
        logic [IW-1:0] oi, k;
        logic [W-1:0] x, y;
        launch(8'h5A, 8'h5A);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks += 4;
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL mid_rst_done: got %b want 0", done); end
        if (eq !== 1'b0) begin failures++; $display("FAIL mid_rst_eq: got %b want 0", eq); end
        if (idx !== '0) begin failures++; $display("FAIL mid_rst_idx: got %0d want 0", idx); end
        for (int i = 0; i < S + 2; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0) begin failures++; $display("FAIL mid_rst_late_done: got %0d want 0", dones); end
        launch(8'h3C, 8'h3C);
        observe(nb, d, oe, oi);
        checks += 3;
        if (nb != S) begin failures++; $display("FAIL post_rst_busy_cycles: got %0d want %0d", nb, S); end
        if (d !== 1'b1) begin failures++; $display("FAIL post_rst_done: got %b want 1", d); end
        if (oe !== 1'b1) begin failures++; $display("FAIL post_rst_eq: got %b want 1", oe); end
        x = W'($urandom);
        y = x ^ (W'(1) << $urandom_range(0, W - 1));
        model(x, y, e, k, n);
        launch(x, y);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b want 1", busy); end
        observe(nb, d, oe, oi);
        checks += 4;
        if (nb != n) begin failures++; $display("FAIL b2b_busy_cycles: got %0d want %0d", nb, n); end
        if (d !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b want 1", d); end
        if (oe !== e) begin failures++; $display("FAIL b2b_eq: got %b want %b", oe, e); end
        if (oi !== k) begin failures++; $display("FAIL b2b_idx: got %0d want %0d", oi, k); end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_ignore_start;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
